// File: rtl/led_seq_pkg.sv
// Shared encodings and helpers for the LED colour-stepper sequencer.
package led_seq_pkg;

   localparam logic [1:0] MODE_OFF    = 2'b00;
   localparam logic [1:0] MODE_MANUAL = 2'b01;
   localparam logic [1:0] MODE_AUTO   = 2'b10;
   localparam logic [1:0] MODE_SEEK   = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_MANUAL,
      ST_AUTO,
      ST_SEEK_CHK,
      ST_SEEK_WAIT
   } state_e;

   localparam logic [2:0] COLOUR_MIN     = 3'b001;
   localparam logic [2:0] COLOUR_MAX     = 3'b110;
   localparam logic [2:0] SEEK_MAX_STEPS = 3'd6;

   // Colours the stepper can actually show.
   function automatic logic colour_valid(input logic [2:0] c);
      return (c >= COLOUR_MIN) && (c <= COLOUR_MAX);
   endfunction

   // Resting state selected by the mode pins; seek only leaves IDLE on start.
   function automatic state_e mode_state(input logic [1:0] m);
      case (m)
         MODE_MANUAL:         return ST_MANUAL;
         MODE_AUTO:           return ST_AUTO;
         MODE_OFF, MODE_SEEK: return ST_IDLE;
         default:             return ST_IDLE;
      endcase
   endfunction

endpackage

// File: rtl/led_seq_ctrl_if.sv
// Board/config side and stepper side signals of the LED sequencer.
interface led_seq_ctrl_if #(
   parameter int DWELL_W = 8
);
   logic               btn_in;
   logic [1:0]         mode;
   logic [DWELL_W-1:0] dwell;
   logic [2:0]         target;
   logic               start;
   logic [2:0]         colour_in;
   logic               step;
   logic               busy;
   logic               done;
   logic               err;

   modport master (
      output btn_in, mode, dwell, target, start, colour_in,
      input  step, busy, done, err
   );

   modport slave (
      input  btn_in, mode, dwell, target, start, colour_in,
      output step, busy, done, err
   );
endinterface

// File: rtl/led_seq_debounce.sv
// Push-button synchronizer and stability filter; emits the accepted level
// and a one-cycle pulse on its rising edge.
module led_seq_debounce #(
   parameter int DEBOUNCE = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_in,
   output logic level,
   output logic rise
);

   localparam int                CNT_W    = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE - 1);

   logic             sync_a;
   logic             sync_b;
   logic [CNT_W-1:0] cnt;

   // Two-flop synchronizer for the asynchronous button.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_a <= 1'b0;
         sync_b <= 1'b0;
      end else begin
         sync_a <= btn_in;
         sync_b <= sync_a;
      end
   end

   // Accept a new level once it has disagreed for DEBOUNCE straight cycles.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         level <= 1'b0;
         rise  <= 1'b0;
         cnt   <= '0;
      end else begin
         rise <= 1'b0;
         if (sync_b != level) begin
            if (cnt == CNT_LAST) begin
               level <= sync_b;
               rise  <= sync_b;
               cnt   <= '0;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end else begin
            cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/led_seq_ctrl.sv
// LED colour-stepper sequencer: off / debounced manual / timed auto / seek.
// Optional step counter output enabled by LED_SEQ_STEP_CNT_EN.
//
// state        | meaning
// -------------+---------------------------------------------------------
// ST_IDLE      | no stepping; accepts seek start when mode is seek
// ST_MANUAL    | one step per debounced button press
// ST_AUTO      | one step every `dwell` cycles
// ST_SEEK_CHK  | compare colour_in to target; step, finish or time out
// ST_SEEK_WAIT | let the stepper settle after a step
module led_seq_ctrl
   import led_seq_pkg::*;
#(
   parameter int DEBOUNCE = 4,
   parameter int DWELL_W  = 8
) (
   input  logic             clk,
   input  logic             rst,
   led_seq_ctrl_if.slave    bus
`ifdef LED_SEQ_STEP_CNT_EN
  ,output logic [7:0]       step_cnt
`endif
);

   state_e             state, state_nx;
   logic               step_q, step_nx;
   logic               busy_q, busy_nx;
   logic               done_q, done_nx;
   logic               err_q, err_nx;
   logic [2:0]         tgt, tgt_nx;
   logic [2:0]         scnt, scnt_nx;
   logic [DWELL_W-1:0] dcnt, dcnt_nx;
   logic               db_level;
   logic               db_rise;

   led_seq_debounce #(.DEBOUNCE(DEBOUNCE)) u_debounce (
      .clk    (clk),
      .rst    (rst),
      .btn_in (bus.btn_in),
      .level  (db_level),
      .rise   (db_rise)
   );

   assign bus.step = step_q;
   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.err  = err_q;

   // State, registered outputs and counters.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= ST_IDLE;
         step_q <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         err_q  <= 1'b0;
         tgt    <= '0;
         scnt   <= '0;
         dcnt   <= '0;
      end else begin
         state  <= state_nx;
         step_q <= step_nx;
         busy_q <= busy_nx;
         done_q <= done_nx;
         err_q  <= err_nx;
         tgt    <= tgt_nx;
         scnt   <= scnt_nx;
         dcnt   <= dcnt_nx;
      end
   end

   // Next state and next output values. The dwell counter defaults to zero so
   // any exit from active auto-stepping (including a mode change) clears it.
   always_comb begin
      state_nx = state;
      step_nx  = 1'b0;
      done_nx  = 1'b0;
      err_nx   = 1'b0;
      tgt_nx   = tgt;
      scnt_nx  = scnt;
      dcnt_nx  = '0;

      case (state)
         ST_IDLE: begin
            state_nx = mode_state(bus.mode);
            if (bus.mode == MODE_SEEK && bus.start) begin
               if (!colour_valid(bus.target)) begin
                  err_nx = 1'b1;
               end else begin
                  tgt_nx   = bus.target;
                  scnt_nx  = '0;
                  state_nx = ST_SEEK_CHK;
               end
            end
         end

         ST_MANUAL: begin
            state_nx = mode_state(bus.mode);
            if (bus.mode == MODE_MANUAL && db_rise && db_level)
               step_nx = 1'b1;
         end

         ST_AUTO: begin
            state_nx = mode_state(bus.mode);
            if (bus.mode == MODE_AUTO && bus.dwell != '0) begin
               if (dcnt == bus.dwell - 1'b1) begin
                  // dwell of 1 would otherwise pulse every cycle
                  step_nx = !step_q;
                  dcnt_nx = '0;
               end else begin
                  dcnt_nx = dcnt + 1'b1;
               end
            end
         end

         ST_SEEK_CHK: begin
            if (bus.mode != MODE_SEEK) begin
               state_nx = ST_IDLE;
            end else if (bus.colour_in == tgt) begin
               done_nx  = 1'b1;
               state_nx = ST_IDLE;
            end else if (scnt == SEEK_MAX_STEPS) begin
               err_nx   = 1'b1;
               state_nx = ST_IDLE;
            end else begin
               step_nx  = 1'b1;
               scnt_nx  = scnt + 3'd1;
               state_nx = ST_SEEK_WAIT;
            end
         end

         ST_SEEK_WAIT: begin
            state_nx = (bus.mode == MODE_SEEK) ? ST_SEEK_CHK : ST_IDLE;
         end

         default: state_nx = ST_IDLE;
      endcase

      busy_nx = (state_nx == ST_SEEK_CHK) || (state_nx == ST_SEEK_WAIT);
   end

`ifdef LED_SEQ_STEP_CNT_EN
   // Saturating count of issued steps, cleared only by reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         step_cnt <= '0;
      else if (step_q && step_cnt != 8'hFF)
         step_cnt <= step_cnt + 8'd1;
   end
`endif

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Scoreboard bench for led_seq_ctrl with a modelled colour stepper.
module tb_led_seq_ctrl;
   import led_seq_pkg::*;

   localparam int DWELL_W  = 8;
   localparam int DEBOUNCE = 4;

   typedef struct {
      int cyc;
      int kind;   // 0 step, 1 done, 2 err
   } ev_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic [2:0] led_colour;
   logic disc = 1'b0;
   int   cyc = 0;
   int   n_vec = 0;
   int   n_err = 0;
   int   cur_col = 1;
   int   exp_steps = 0;
   logic prev_step = 1'b0;
   ev_t  exp_q[$];

   always #5 clk = ~clk;

   led_seq_ctrl_if #(.DWELL_W(DWELL_W)) bus();

`ifdef LED_SEQ_STEP_CNT_EN
   logic [7:0] step_cnt;
`endif

   led_seq_ctrl #(.DEBOUNCE(DEBOUNCE), .DWELL_W(DWELL_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
`ifdef LED_SEQ_STEP_CNT_EN
     ,.step_cnt (step_cnt)
`endif
   );

   // Colour stepper: 001..110, wraps, advances once per clock with button high.
   always @(posedge clk or negedge rst) begin
      if (!rst) led_colour <= 3'b001;
      else if (bus.step) led_colour <= (led_colour == 3'b110) ? 3'b001 : led_colour + 3'd1;
   end
   assign bus.colour_in = disc ? 3'b010 : led_colour;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic string kname(input int k);
      return (k == 0) ? "step" : (k == 1) ? "done" : "err";
   endfunction

   function automatic int adv(input int c, input int n);
      return ((c - 1 + n) % 6) + 1;
   endfunction

   task automatic expect_ev(input int c, input int k);
      ev_t e;
      e.cyc = c;
      e.kind = k;
      exp_q.push_back(e);
      if (k == 0) exp_steps++;
   endtask

   task automatic check(input string name, input int act, input int req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0d, required %0d (cyc %0d)", name, act, req, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Monitor: every observed pulse must match a scheduled event; overdue
   // scheduled events are reported as missed.
   always @(negedge clk) begin
      logic [2:0] obs;
      int found;
      if (rst) begin
         for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].cyc < cyc) begin
               n_vec++;
               n_err++;
               $display("FAIL missed_%s: not seen, required at cyc %0d (now %0d)",
                        kname(exp_q[i].kind), exp_q[i].cyc, cyc);
               exp_q.delete(i);
            end
         end
         obs = {bus.err, bus.done, bus.step};
         for (int k = 0; k < 3; k++) begin
            if (obs[k]) begin
               n_vec++;
               found = -1;
               for (int i = 0; i < exp_q.size(); i++)
                  if (found < 0 && exp_q[i].cyc == cyc && exp_q[i].kind == k) found = i;
               if (found >= 0) exp_q.delete(found);
               else begin
                  n_err++;
                  $display("FAIL unexpected_%s: seen at cyc %0d, required none", kname(k), cyc);
               end
            end
         end
         if (bus.step) begin
            n_vec++;
            if (prev_step) begin
               n_err++;
               $display("FAIL step_back_to_back: step high at cyc %0d and %0d, required isolated", cyc - 1, cyc);
            end
         end
         prev_step = bus.step;
      end else begin
         prev_step = 1'b0;
      end
   end

   task automatic press(input int len);
      int c;
      c = cyc;
      bus.btn_in = 1'b1;
      if (len >= DEBOUNCE) expect_ev(c + 7, 0);
      tick(len);
      bus.btn_in = 1'b0;
      tick(12);
      if (len >= DEBOUNCE) cur_col = adv(cur_col, 1);
   endtask

   task automatic auto_run(input int d, input int len);
      int c, cnt;
      c = cyc;
      cnt = 0;
      bus.dwell = DWELL_W'(d);
      bus.mode = MODE_AUTO;
      if (d > 0)
         for (int t = c + 1 + d; t <= c + len; t += d) begin
            expect_ev(t, 0);
            cnt++;
         end
      tick(len);
      bus.mode = MODE_OFF;
      cur_col = adv(cur_col, cnt);
      tick(3);
      check("auto_colour", int'(led_colour), cur_col);
   endtask

   task automatic do_seek(input int t, input bit restart);
      int c, n;
      c = cyc;
      bus.target = 3'(t);
      bus.start = 1'b1;
      tick(1);
      bus.start = 1'b0;
      if (t < 1 || t > 6) begin
         expect_ev(c + 1, 2);
         check("seek_bad_busy", int'(bus.busy), 0);
         tick(3);
      end else begin
         n = (t - cur_col + 6) % 6;
         for (int k = 0; k < n; k++) expect_ev(c + 2 + 2 * k, 0);
         expect_ev(c + 2 + 2 * n, 1);
         check("seek_busy_start", int'(bus.busy), 1);
         for (int i = 0; i < 2 * n; i++) begin
            if (restart && i == 1) begin
               bus.target = 3'd7;
               bus.start = 1'b1;
            end
            tick(1);
            bus.start = 1'b0;
            check("seek_busy_mid", int'(bus.busy), 1);
         end
         tick(1);
         check("seek_busy_end", int'(bus.busy), 0);
         cur_col = t;
         tick(2);
         check("seek_colour", int'(led_colour), cur_col);
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int c, d, r;
      bus.btn_in = 1'b0;
      bus.mode = MODE_OFF;
      bus.dwell = '0;
      bus.target = '0;
      bus.start = 1'b0;
      tick(3);
      check("rst_step", int'(bus.step), 0);
      check("rst_busy", int'(bus.busy), 0);
      check("rst_done", int'(bus.done), 0);
      check("rst_err",  int'(bus.err), 0);
      rst = 1'b1;
      tick(2);

      // Manual stepping, glitches and ignored start.
      bus.mode = MODE_MANUAL;
      tick(3);
      press(10);
      press(2);
      bus.target = 3'd7;
      bus.start = 1'b1;
      tick(1);
      bus.start = 1'b0;
      tick(2);
      for (int i = 0; i < 4; i++) press($urandom_range(4, 12));
      press($urandom_range(1, 3));
      check("manual_colour", int'(led_colour), cur_col);
      bus.mode = MODE_OFF;
      tick(2);

      // Auto stepping.
      auto_run(5, 41);
      tick(2);
      auto_run(0, 30);
      tick(2);
      for (int i = 0; i < 2; i++) begin
         auto_run($urandom_range(2, 9), $urandom_range(15, 40));
         tick(2);
      end

      // Seek.
      bus.mode = MODE_SEEK;
      tick(2);
      do_seek(1, 1'b0);
      do_seek(1, 1'b0);
      do_seek(6, 1'b1);
      do_seek(7, 1'b0);
      do_seek(0, 1'b0);
      for (int i = 0; i < 5; i++) do_seek($urandom_range(0, 7), 1'b0);

      // Stepper not responding: colour stuck at 010.
      disc = 1'b1;
      tick(1);
      c = cyc;
      bus.target = 3'd4;
      bus.start = 1'b1;
      for (int k = 0; k < 6; k++) expect_ev(c + 2 + 2 * k, 0);
      expect_ev(c + 14, 2);
      tick(1);
      bus.start = 1'b0;
      tick(15);
      check("timeout_busy", int'(bus.busy), 0);
      disc = 1'b0;
      tick(1);
      check("timeout_colour", int'(led_colour), cur_col);

      // Abort a seek after two steps, then press in manual.
      c = cyc;
      bus.target = 3'(adv(cur_col, 3));
      bus.start = 1'b1;
      expect_ev(c + 2, 0);
      expect_ev(c + 4, 0);
      tick(1);
      bus.start = 1'b0;
      tick(3);
      bus.mode = MODE_MANUAL;
      tick(1);
      check("abort_busy", int'(bus.busy), 0);
      cur_col = adv(cur_col, 2);
      tick(3);
      press(10);
      check("abort_colour", int'(led_colour), cur_col);
      bus.mode = MODE_OFF;
      tick(2);

      // Asynchronous reset in the middle of an auto run.
      d = $urandom_range(3, 7);
      c = cyc;
      bus.dwell = DWELL_W'(d);
      bus.mode = MODE_AUTO;
      for (int k = 1; k <= 3; k++) expect_ev(c + 1 + k * d, 0);
      tick(1 + 3 * d);
      #2 rst = 1'b0;
      #1;
      check("midrst_step", int'(bus.step), 0);
      check("midrst_busy", int'(bus.busy), 0);
      check("midrst_done", int'(bus.done), 0);
      check("midrst_err",  int'(bus.err), 0);
      exp_steps = 0;
      tick(2);
      rst = 1'b1;
      r = cyc;
      for (int k = 1; k <= 3; k++) expect_ev(r + 1 + k * d, 0);
      tick(1 + 3 * d);
      bus.mode = MODE_OFF;
      cur_col = adv(1, 3);
      tick(3);
      check("post_rst_colour", int'(led_colour), cur_col);

      tick(5);
      check("queue_drained", exp_q.size(), 0);
`ifdef LED_SEQ_STEP_CNT_EN
      check("step_cnt", int'(step_cnt), (exp_steps > 255) ? 255 : exp_steps);
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/led_seq_ctrl.md
Name: led_seq_ctrl

Overview:
Controller that sequences the dynamic-LED colour stepper (the `led` block: colour cycles 001..110 and wraps to 001, advancing one colour per clock while its `button` is high).
- Drives the stepper's `button` input with single-cycle `step` pulses and monitors its `colour` output.
- Four modes: off; debounced manual stepping; timed auto-cycling; seek-to-target-colour.
- Sits between board push-button/config registers and the `led` instance.

Parameters:
DEBOUNCE, 4, cycles the synchronized button must stay stable before its level is accepted (>=1)
DWELL_W, 8, width of the auto-mode dwell count

Ports:
clk  in  1  system clock
rst  in  1  reset: asynchronous, active-low
btn_in  in  1  raw push-button, asynchronous to clk
mode  in  2  00 off, 01 manual, 10 auto, 11 seek
dwell  in  DWELL_W  auto mode: cycles between steps; 0 disables stepping
target  in  3  seek target colour
start  in  1  seek trigger, one-cycle pulse
colour_in  in  3  colour output of the led stepper
step  out  1  one-cycle pulse to led.button
busy  out  1  high while a seek is in progress
done  out  1  one-cycle pulse: seek reached target
err  out  1  one-cycle pulse: invalid target or seek timeout

Behaviour:
- Reset (rst=0, any time, async): step=0, busy=0, done=0, err=0; state IDLE; all counters 0; debounce level 0.
- step is registered and never high on two consecutive cycles. The stepper reflects a step one cycle after the step pulse.
- States: IDLE, MANUAL, AUTO, SEEK_CHK, SEEK_WAIT.
  - Outside seek, state follows mode on the next clock edge: 00->IDLE, 01->MANUAL, 10->AUTO, 11->IDLE until start.
  - Every mode change clears the dwell counter and discards any pending manual edge.
- Debounce:
  - btn_in passes through a 2-flop synchronizer.
  - The debounced level updates only after the synchronized value has differed from it for DEBOUNCE consecutive cycles.
- MANUAL: each 0->1 transition of the debounced level gives exactly one step pulse, on the cycle after the transition. Holding the button gives no further steps.
- AUTO:
  - Dwell counter increments each cycle.
  - When counter == dwell-1 and dwell != 0: step=1 and counter returns to 0, so the step period is dwell cycles.
  - dwell==0: no steps, counter held at 0.
  - dwell changed mid-count: compared on the next cycle. If counter already exceeds the new dwell-1, the counter wraps naturally at 2^DWELL_W.
- Seek, from IDLE with mode==11 and start=1:
  - target is 000 or 111: err pulse next cycle, stay IDLE, no steps.
  - Otherwise latch target, clear step counter, busy=1, go to SEEK_CHK.
- SEEK_CHK:
  - colour_in == latched target: done pulse, busy=0, go to IDLE (0 steps if already there).
  - Else if step counter == 6: err pulse, busy=0, go to IDLE. This covers a stepper that is not responding.
  - Else step=1, counter+1, go to SEEK_WAIT.
- SEEK_WAIT: one cycle, then SEEK_CHK. Worst-case legal seek is 5 steps over 10 cycles.
- Mode leaves 11 during seek: abort to IDLE, busy=0, no done/err. start while busy is ignored. start in modes 00/01/10 is ignored.
- done and err are never high in the same cycle.

Optional Feature:
LED_SEQ_STEP_CNT_EN:
- Defined: adds output step_cnt[7:0], which increments on every step pulse, saturates at 255, and is cleared only by reset.
- Undefined: no port and no counter logic; all other behaviour identical.

Decomposition:
- Package led_seq_pkg holds:
  - mode encodings MODE_OFF/MODE_MANUAL/MODE_AUTO/MODE_SEEK
  - state encoding
  - COLOUR_MIN=3'b001, COLOUR_MAX=3'b110
  - SEEK_MAX_STEPS=6
- One sub-module, led_seq_debounce: synchronizer plus stable counter; outputs the debounced level and a rising-edge pulse.

Test Plan:
- Reset: hold rst=0 mid-auto-run -> step=busy=done=err=0 immediately; after release, no step for dwell cycles.
- Manual:
  - btn_in high for 10 cycles with DEBOUNCE=4 -> exactly one step, 7 cycles after the btn_in edge (2 sync + 4 stable + 1); led 001->010.
  - 2-cycle glitch -> no step.
- Auto, dwell=5, 40 cycles -> 8 steps spaced exactly 5 cycles apart; led wraps 110->001.
  - dwell=0 -> no steps.
- Seek from 001:
  - target=110 -> 5 steps, done pulse, busy high throughout, colour_in=110.
  - target=001 -> done with 0 steps.
- Seek errors:
  - target=111 -> err pulse, no steps.
  - colour_in held at 010 (stepper disconnected), target=100 -> 6 steps then err.
- Abort: mode 11->01 after 2 seek steps -> busy=0, no done/err, next debounced press steps normally.
